// File: rtl/ex_mdu_seq.sv
// RV32M multiply/divide sequencer beside EX.
// Shift-add multiply / restoring divide, one bit per cycle.
module ex_mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      wreg_in,
  input  logic            flush,
  input  logic            pipe_hold,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wreg_out
);

  localparam int CW = $clog2(XLEN);
  localparam int AW = 2*XLEN+1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   acc_q;

  logic            sgn1, sgn2, neg1, neg2, neg_in;
  logic [XLEN-1:0] abs1, abs2;
  logic            div_zero, ovf, special, accept;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    sgn1 = ~(funct3[0] & (funct3[1] | funct3[2]));
    sgn2 = (funct3 == 3'b001) | (funct3 == 3'b100) |
           (funct3 == 3'b110);
    neg1 = sgn1 & rs1_val[XLEN-1];
    neg2 = sgn2 & rs2_val[XLEN-1];
    abs1 = neg1 ? -rs1_val : rs1_val;
    abs2 = neg2 ? -rs2_val : rs2_val;
    neg_in = (funct3[2] & funct3[1]) ? neg1 : (neg1 ^ neg2);
    div_zero = funct3[2] & (rs2_val == '0);
    ovf = funct3[2] & ~funct3[0] & (rs1_val == MIN) &
          (rs2_val == '1);
    special = div_zero | ovf;
    spec_res = '0;
    if (div_zero)
      spec_res = funct3[1] ? rs1_val : '1;
    else
      spec_res = funct3[1] ? '0 : MIN;
    accept = (state == IDLE) & start & ~flush;
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   trial;
  logic [AW-1:0]     sh, mul_nxt, div_nxt, acc_nxt;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]   quo_f, rem_f, fin_res;
  logic              last;

  always_comb begin
    mul_sum = acc_q[AW-1:XLEN] + {1'b0, a_q};
    if (acc_q[0])
      mul_nxt = {1'b0, mul_sum, acc_q[XLEN-1:1]};
    else
      mul_nxt = {1'b0, acc_q[AW-1:1]};
    sh = {acc_q[AW-2:0], 1'b0};
    trial = {1'b0, sh[AW-1:XLEN]} - {2'b00, b_q};
    if (!trial[XLEN+1])
      div_nxt = {trial[XLEN:0], sh[XLEN-1:0]} | AW'(1);
    else
      div_nxt = sh;
    acc_nxt = op_q[2] ? div_nxt : mul_nxt;
    prod   = acc_nxt[2*XLEN-1:0];
    prod_f = neg_q ? -prod : prod;
    quo_f  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_f  = neg_q ? -acc_nxt[2*XLEN-1:XLEN]
                   : acc_nxt[2*XLEN-1:XLEN];
    fin_res = rem_f;
    unique case (op_q)
      3'b000:  fin_res = prod_f[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  fin_res = prod_f[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  fin_res = quo_f;
      default: fin_res = rem_f;
    endcase
    last = (cnt_q == CW'(XLEN-1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: if (flush || !pipe_hold) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the combinational hold so outputs drop at once.
  assign stall_req = rst & ~flush &
                     (((state == IDLE) & start & ~special) |
                      (state == CALC));
  assign busy = (state != IDLE);
  assign done = (state == DONE) & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result   <= '0;
      wreg_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= funct3;
        wreg_out <= wreg_in;
        a_q      <= abs1;
        b_q      <= abs2;
        neg_q    <= neg_in;
        cnt_q    <= '0;
        acc_q    <= {{(XLEN+1){1'b0}},
                     (funct3[2] ? abs1 : abs2)};
        if (special) result <= spec_res;
      end else if (state == CALC && !flush) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + CW'(1);
        if (last) result <= fin_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Bench for ex_mdu_seq: queued expectations from an
// arithmetic model, checked by a done-driven monitor.
module tb_ex_mdu_seq;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  wreg_in;
  logic        flush, pipe_hold;
  logic        stall_req, busy, done;
  logic [31:0] result;
  logic [4:0]  wreg_out;

  ex_mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .wreg_in(wreg_in),
    .flush(flush), .pipe_hold(pipe_hold),
    .stall_req(stall_req), .busy(busy), .done(done),
    .result(result), .wreg_out(wreg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  w;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(
      input logic [2:0] f, input logic [31:0] a, b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] u;
    logic signed [31:0] ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  logic [31:0] last_res;
  logic [4:0]  last_w;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h expected none",
                 result);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("wreg_out", {27'b0, wreg_out}, {27'b0, e.w});
      end
      last_res = result;
      last_w = wreg_out;
    end else if (done && prev_done) begin
      check("hold_result", result, last_res);
      check("hold_wreg", {27'b0, wreg_out}, {27'b0, last_w});
    end
    prev_done = done;
  end

  task automatic run_op(input logic [2:0] f,
                        input logic [31:0] a, b,
                        input int hold);
    logic sp;
    int cyc;
    bit got;
    exp_t e;
    sp = f[2] && (b == 0 ||
         (!f[0] && a == MIN && b == 32'hFFFF_FFFF));
    @(posedge clk); #1;
    start = 1'b1;
    funct3 = f;
    rs1_val = a;
    rs2_val = b;
    wreg_in = 5'($urandom);
    e.res = ref_op(f, a, b);
    e.w = wreg_in;
    exp_q.push_back(e);
    got = 0;
    cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (cyc <= 33)
        check("stall_req", {31'b0, stall_req},
              {31'b0, (!sp && cyc <= 32)});
      if (done) got = 1;
      else cyc++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no done expected done f=%0d", f);
    end else begin
      check("latency", cyc, sp ? 1 : 33);
    end
    for (int k = 0; k < hold; k++) begin
      pipe_hold = 1'b1;
      @(negedge clk);
      check("held_done", {31'b0, done}, 32'd1);
    end
    pipe_hold = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_after", {30'b0, busy, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return MIN;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    start = 1'b0;
    funct3 = '0;
    rs1_val = '0;
    rs2_val = '0;
    wreg_in = '0;
    flush = 1'b0;
    pipe_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs",
          {stall_req, busy, done, result, wreg_out}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(3'd4, 32'd5, 32'd0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    run_op(3'd4, MIN, 32'hFFFF_FFFF, 0);
    run_op(3'd6, MIN, 32'hFFFF_FFFF, 0);
    for (int f = 0; f < 4; f++)
      run_op(3'(f), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // flush mid-divide, then a fresh op two cycles later
    @(posedge clk); #1;
    start = 1'b1;
    funct3 = 3'd5;
    rs1_val = 32'd100;
    rs2_val = 32'd7;
    wreg_in = 5'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'b0, stall_req}, 32'd0);
    check("flush_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("flush_idle", {30'b0, busy, done}, 32'd0);
    run_op(3'd5, 32'd1000, 32'd9, 0);

    run_op(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3);
    run_op(3'd4, 32'd9, 32'd0, 3);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(),
             ($urandom_range(0, 3) == 0) ? 2 : 0);

    // async reset during CALC with start still high
    @(posedge clk); #1;
    start = 1'b1;
    funct3 = 3'd1;
    rs1_val = $urandom;
    rs2_val = $urandom;
    wreg_in = 5'd17;
    repeat (10) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_ctl", {29'b0, stall_req, busy, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_wreg", {27'b0, wreg_out}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd6, 32'hFFFF_FF00, 32'd7, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mdu_seq.md
Name: ex_mdu_seq

Overview:
Iterative multiply/divide sequencer for the RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the execute stage, which feeds it forwarded operands and funct3.
- Holds the pipeline through the stage's existing keep mechanism while a 32-step shift-add or restoring-divide runs.
- Presents a registered result that the execute stage muxes into its ALU result register on the done cycle.

Parameters:
XLEN, 32, operand/result width; must be a power of 2; the iteration count equals XLEN.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  M-extension instruction valid in EX (level; stays high while EX is held)
funct3  in  3  RV32M op select
rs1_val  in  XLEN  forwarded operand 1 (dividend / multiplicand)
rs2_val  in  XLEN  forwarded operand 2 (divisor / multiplier)
wreg_in  in  5  destination register of the op
flush  in  1  branch/trap kill of the EX instruction
pipe_hold  in  1  downstream stall; result must be held
stall_req  out  1  to EX/ID/IF keep; holds the instruction in EX
busy  out  1  state != IDLE
done  out  1  result valid this cycle
result  out  XLEN  registered result
wreg_out  out  5  latched destination register

Behaviour:
- Reset: state=IDLE; all outputs and internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE, start=1 and flush=0:
  - latch funct3, wreg_in, |rs1|, |rs2|; signedness per op (rs1 signed for 000/001/010/100/110; rs2 signed for 001/100/110).
  - record neg_res: products = sign1^sign2; quotient = sign1^sign2; remainder = sign1.
  - count=0; go to CALC.
- Special cases in IDLE go directly to DONE, with result registered on the same edge:
  - DIV/DIVU with rs2=0: 0xFFFFFFFF.
  - REM/REMU with rs2=0: rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: 0x80000000.
  - REM with the same operands: 0.
- CALC, one step per cycle:
  - mul: if multiplier LSB set, add multiplicand into upper half of 2*XLEN accumulator; shift right.
  - div: restoring; shift {rem,quot} left, trial subtract divisor, set quot bit if non-negative.
  - after count==XLEN-1: apply two's-complement negation if neg_res; select low/high product, quotient or remainder; register into result; go to DONE.
- DONE: done=1, stall_req=0.
  - pipe_hold=1: stay in DONE; result/wreg_out stable.
  - else: IDLE next cycle.
  - start is ignored in DONE (same instruction still present); a new op is accepted only from IDLE.
- stall_req = !flush & ((state==IDLE & start & normal op) | state==CALC). It is combinational so the start cycle itself holds EX.
- Latency: start at cycle 0 → done at cycle XLEN+1 (33). Special case → done at cycle 1. stall_req high cycles 0..32 (0 only for specials, where stall_req=0).
- flush in any state: stall_req forced 0 that cycle; next state IDLE; done never asserted for that op; result keeps its old value.
- start while busy: ignored.
- Reset mid-operation: immediate IDLE, outputs 0.
- All arithmetic is modulo 2^XLEN; the accumulator is 2*XLEN+1 bits for the divide trial subtract.

Test Plan:
1. DIVU 100/7, start held → stall_req=1 cycles 0–32; done=1 at cycle 33, result=14. REMU → 2.
2. DIV 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIV 7/0xFFFFFFFE → 0xFFFFFFFD. REM → 1.
3. DIV 5/0 → 0xFFFFFFFF at cycle 1. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; both done at cycle 1 with stall_req never high.
4. rs1=rs2=0xFFFFFFFF: MUL → 1, MULH → 0, MULHU → 0xFFFFFFFE, MULHSU → 0xFFFFFFFF. Also 0x12345678*0x9ABCDEF0: MULHU → 0x0B00EA4E, MUL → 0x242D2080.
5. Flush: flush at cycle 10 of DIVU → stall_req=0 at cycle 10, IDLE at cycle 11, no done. New start at cycle 12 → done at cycle 45.
6. pipe_hold=1 for 3 cycles at DONE → done and result stable 4 cycles; start held meanwhile does not restart. Async rst low mid-CALC → all outputs 0 immediately.
